// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, line/frame timing and lock status from a sampled VGA stream.
// Define VGA_RX_FRAME_SUM_EN to build the per-frame R+G+B checksum; otherwise frame_sum is tied to zero.
module vga_sync_decoder #(
  parameter int unsigned N = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_en,
  input  logic [7:0]   R,
  input  logic [7:0]   G,
  input  logic [7:0]   B,
  input  logic         horiz_sync,
  input  logic         vert_sync,
  input  logic         vga_blank,
  output logic [N:0]   pix_x,
  output logic [N:0]   pix_y,
  output logic         pix_valid,
  output logic [7:0]   pix_R,
  output logic [7:0]   pix_G,
  output logic [7:0]   pix_B,
  output logic [N:0]   h_total,
  output logic [N:0]   v_total,
  output logic         frame_start,
  output logic         locked,
  output logic         sync_err,
  output logic [15:0]  frame_sum
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [N:0] CNT_MAX = '1;
  localparam logic [N:0] ONE     = 1;

  logic         hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic         h_edge, v_edge;
  logic [N:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [N:0]   h_total_q, h_total_d, v_total_q, v_total_d;
  logic [N:0]   x_q, x_d, y_q, y_d;
  logic         line_act_q, line_act_d;
  logic [N:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic         pix_valid_q, pix_valid_d;
  logic [7:0]   pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic         frame_start_q, frame_start_d;
  logic [1:0]   state_q, state_d;
  logic [N:0]   ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic         sync_err_q, sync_err_d;

  // Sync edges are only seen between consecutive strobed samples.
  assign h_edge = pix_en & hs_prev_q & ~horiz_sync;
  assign v_edge = pix_en & vs_prev_q & ~vert_sync;

  always_comb begin : edge_regs
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    if (pix_en) begin
      hs_prev_d = horiz_sync;
      vs_prev_d = vert_sync;
    end
  end

  always_comb begin : timing_measure
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    if (pix_en) begin
      if (h_edge) begin
        h_total_d = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + ONE;
        h_cnt_d   = '0;
        v_cnt_d   = v_cnt_q + ONE;
      end else if (h_cnt_q != CNT_MAX) begin
        h_cnt_d = h_cnt_q + ONE;
      end
      // A coincident line start belongs to the frame being closed.
      if (v_edge) begin
        v_total_d = h_edge ? v_cnt_q + ONE : v_cnt_q;
        v_cnt_d   = '0;
      end
    end
  end

  always_comb begin : coords
    x_d        = x_q;
    y_d        = y_q;
    line_act_d = line_act_q;
    if (pix_en) begin
      if (h_edge) begin
        x_d        = '0;
        line_act_d = vga_blank;
        if (line_act_q) y_d = y_q + ONE;
      end else begin
        if (vga_blank) x_d = x_q + ONE;
        line_act_d = line_act_q | vga_blank;
      end
      if (v_edge) y_d = '0;
    end
  end

  always_comb begin : pixel_out
    pix_valid_d   = pix_en & vga_blank;
    frame_start_d = v_edge;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    if (pix_valid_d) begin
      pix_x_d = x_q;
      pix_y_d = y_q;
      pix_r_d = R;
      pix_g_d = G;
      pix_b_d = B;
    end
  end

  // Reference is cleared on entering MEASURE so lock always needs two fresh frames.
  always_comb begin : lock_fsm
    state_d    = state_q;
    ref_h_d    = ref_h_q;
    ref_v_d    = ref_v_q;
    sync_err_d = 1'b0;
    if (pix_en) begin
      case (state_q)
        ST_SEARCH: begin
          if (v_edge) begin
            state_d = ST_MEASURE;
            ref_h_d = '0;
            ref_v_d = '0;
          end
        end
        ST_MEASURE: begin
          if (v_edge) begin
            ref_h_d = h_total_d;
            ref_v_d = v_total_d;
            if (h_total_d == ref_h_q && v_total_d == ref_v_q) state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if ((v_edge && (h_total_d != ref_h_q || v_total_d != ref_v_q)) ||
              (h_edge && h_total_d != ref_h_q)) begin
            sync_err_d = 1'b1;
            state_d    = ST_SEARCH;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_act_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      frame_start_q <= 1'b0;
      state_q       <= ST_SEARCH;
      ref_h_q       <= '0;
      ref_v_q       <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_act_q    <= line_act_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= pix_valid_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
      ref_h_q       <= ref_h_d;
      ref_v_q       <= ref_v_d;
      sync_err_q    <= sync_err_d;
    end
  end

`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d, rgb_sum;

  assign rgb_sum = 16'(R) + 16'(G) + 16'(B);

  // The vert_sync sample itself starts the new frame's accumulation.
  always_comb begin : frame_checksum
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    if (pix_en) begin
      if (v_edge) begin
        frame_sum_d = acc_q;
        acc_d       = vga_blank ? rgb_sum : '0;
      end else if (vga_blank) begin
        acc_d = acc_q + rgb_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_R       = pix_r_q;
  assign pix_G       = pix_g_q;
  assign pix_B       = pix_b_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == ST_LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: frame generator, sample-level reference model checked every clock,
// plus literal expectations for lock, measurement, coordinate and checksum behaviour.
module tb_vga_sync_decoder;

  localparam int N    = 15;
  localparam int CMAX = 65535;

  logic         clk = 1'b0;
  logic         reset, pix_en, hs, vs, blank;
  logic [7:0]   r_in, g_in, b_in;
  logic [N:0]   pix_x, pix_y, h_total, v_total;
  logic         pix_valid, frame_start, locked, sync_err;
  logic [7:0]   pix_R, pix_G, pix_B;
  logic [15:0]  frame_sum;

  always #5 clk = ~clk;

  vga_sync_decoder #(.N(N)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .R(r_in), .G(g_in), .B(b_in),
    .horiz_sync(hs), .vert_sync(vs), .vga_blank(blank),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
    .h_total(h_total), .v_total(v_total), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .frame_sum(frame_sum)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x, y, val, r, g, b, ht, vt, fs, lk, err, sum;
  } exp_t;

  exp_t cur, nxt;

  // Reference model state: samples seen, not RTL registers.
  int m_hp, m_vp, m_hc, m_vc, m_x, m_y, m_la, m_acc, m_rh, m_rv, m_mode;

  // Observed-stream statistics
  int fs_cnt = 0, err_cnt = 0, pv_cnt = 0;
  int fx, fy, lx, ly;
  int done_cnt = 0, done_fx = 0, done_fy = 0, done_lx = 0, done_ly = 0;

  int s_idx = 0;
  bit const_rgb = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    nxt    = '{default: 0};
    m_hp   = 1; m_vp = 1;
    m_hc   = 0; m_vc = 0; m_x = 0; m_y = 0; m_la = 0;
    m_acc  = 0; m_rh = 0; m_rv = 0; m_mode = 0;
  endtask

  task automatic model_step(input bit en, input bit h, input bit v, input bit bl,
                            input int rr, input int gg, input int bb);
    bit hf, vf;
    int ht, vt;
    nxt.val = 0; nxt.fs = 0; nxt.err = 0;
    if (!en) return;
    hf = (m_hp == 1) && !h;
    vf = (m_vp == 1) && !v;
    ht = hf ? ((m_hc + 1 > CMAX) ? CMAX : m_hc + 1) : nxt.ht;
    vt = vf ? ((m_vc + int'(hf)) % (CMAX + 1)) : nxt.vt;
    if (bl) begin
      nxt.val = 1; nxt.x = m_x; nxt.y = m_y;
      nxt.r = rr; nxt.g = gg; nxt.b = bb;
    end
    nxt.fs = int'(vf); nxt.ht = ht; nxt.vt = vt;
    case (m_mode)
      0: if (vf) begin m_mode = 1; m_rh = 0; m_rv = 0; end
      1: if (vf) begin
           if (ht == m_rh && vt == m_rv) m_mode = 2;
           m_rh = ht; m_rv = vt;
         end
      default: if ((vf && (ht != m_rh || vt != m_rv)) || (hf && ht != m_rh)) begin
           nxt.err = 1; m_mode = 0;
         end
    endcase
    nxt.lk = (m_mode == 2) ? 1 : 0;
`ifdef VGA_RX_FRAME_SUM_EN
    if (vf) begin nxt.sum = m_acc; m_acc = 0; end
    if (bl) m_acc = (m_acc + rr + gg + bb) % 65536;
`endif
    if (hf) begin
      if (m_la != 0) m_y++;
      m_x = 0; m_la = int'(bl);
    end else begin
      if (bl) m_x++;
      if (bl) m_la = 1;
    end
    if (vf) m_y = 0;
    m_hc = hf ? 0 : ((m_hc + 1 > CMAX) ? CMAX : m_hc + 1);
    m_vc = vf ? 0 : (m_vc + int'(hf)) % (CMAX + 1);
    m_hp = int'(h); m_vp = int'(v);
  endtask

  task automatic compare_all();
    chk("pix_valid",   32'(pix_valid),   cur.val);
    chk("frame_start", 32'(frame_start), cur.fs);
    chk("sync_err",    32'(sync_err),    cur.err);
    chk("locked",      32'(locked),      cur.lk);
    chk("h_total",     32'(h_total),     cur.ht);
    chk("v_total",     32'(v_total),     cur.vt);
    chk("pix_x",       32'(pix_x),       cur.x);
    chk("pix_y",       32'(pix_y),       cur.y);
    chk("pix_R",       32'(pix_R),       cur.r);
    chk("pix_G",       32'(pix_G),       cur.g);
    chk("pix_B",       32'(pix_B),       cur.b);
    chk("frame_sum",   32'(frame_sum),   cur.sum);
  endtask

  task automatic monitor();
    if (frame_start === 1'b1) begin
      fs_cnt++;
      done_cnt = pv_cnt; done_fx = fx; done_fy = fy; done_lx = lx; done_ly = ly;
      pv_cnt = 0;
    end
    if (pix_valid === 1'b1) begin
      if (pv_cnt == 0) begin fx = int'(pix_x); fy = int'(pix_y); end
      lx = int'(pix_x); ly = int'(pix_y);
      pv_cnt++;
    end
    if (sync_err === 1'b1) err_cnt++;
  endtask

  // One clock: advance expectation, drive after the edge, check on the falling edge.
  task automatic cycle(input bit rst_n, input bit en, input bit h, input bit v, input bit bl,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    @(posedge clk);
    cur = nxt;
    #1;
    reset = rst_n; pix_en = en; hs = h; vs = v; blank = bl;
    r_in = rr; g_in = gg; b_in = bb;
    if (!rst_n) model_reset();
    else model_step(en, h, v, bl, int'(rr), int'(gg), int'(bb));
    @(negedge clk);
    compare_all();
    monitor();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    idle();
  endtask

  // Strobed sample followed by a non-strobed cycle carrying inverted junk.
  task automatic do_sample(input bit h, input bit v, input bit bl);
    logic [7:0] rr, gg, bb;
    logic [31:0] s;
    s  = 32'(s_idx);
    rr = const_rgb ? 8'd1 : s[7:0];
    gg = const_rgb ? 8'd1 : s[10:3];
    bb = const_rgb ? 8'd1 : 8'(s * 7);
    cycle(1'b1, 1'b1, h, v, bl, rr, gg, bb);
    cycle(1'b1, 1'b0, ~h, ~v, ~bl, ~rr, ~gg, ~bb);
    s_idx++;
  endtask

  // Each line starts with its horiz_sync assertion; vert_sync asserts with line 0.
  task automatic send_frame(input int hl, input int hsw, input int hbp, input int aw,
                            input int vl, input int vsw, input int vbp, input int ah,
                            input int max_lines, input int short_line, input int rst_line);
    int len;
    bit h, v, bl;
    for (int ln = 0; ln < vl && ln < max_lines; ln++) begin
      len = (ln == short_line) ? hl - 1 : hl;
      for (int s = 0; s < len; s++) begin
        if (ln == rst_line && s == hl / 2) begin
          do_reset();
          chk("rst_pix_valid", 32'(pix_valid), 0);
          chk("rst_h_total",   32'(h_total),   0);
          chk("rst_v_total",   32'(v_total),   0);
          chk("rst_pix_x",     32'(pix_x),     0);
          chk("rst_pix_y",     32'(pix_y),     0);
          chk("rst_pix_R",     32'(pix_R),     0);
          chk("rst_locked",    32'(locked),    0);
          chk("rst_frame_sum", 32'(frame_sum), 0);
        end
        h  = (s >= hsw);
        v  = (ln >= vsw);
        bl = (ln >= vsw + vbp) && (ln < vsw + vbp + ah) && (s >= hsw + hbp) && (s < hsw + hbp + aw);
        do_sample(h, v, bl);
      end
    end
  endtask

  task automatic small_frame(input int short_line, input int rst_line);
    send_frame(40, 4, 4, 24, 20, 2, 3, 12, 20, short_line, rst_line);
  endtask

  int err_base, fs_base;

  initial begin
    reset = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    model_reset();
    do_reset();
    chk("reset_h_total",     32'(h_total),     0);
    chk("reset_v_total",     32'(v_total),     0);
    chk("reset_locked",      32'(locked),      0);
    chk("reset_pix_valid",   32'(pix_valid),   0);
    chk("reset_frame_start", 32'(frame_start), 0);
    chk("reset_sync_err",    32'(sync_err),    0);
    chk("reset_frame_sum",   32'(frame_sum),   0);

    // Lock acquisition on a small 40x20 raster, constant colour for the checksum.
    const_rgb = 1'b1;
    err_base  = err_cnt;
    small_frame(-1, -1);
    small_frame(-1, -1);
    chk("A_locked_before_3rd", 32'(locked),  0);
    chk("A_h_total",           32'(h_total), 40);
    chk("A_v_total",           32'(v_total), 20);
    small_frame(-1, -1);
    chk("A_locked",            32'(locked),  1);
    chk("A_model_locked",      32'(cur.lk),  1);
    chk("A_model_h_total",     32'(cur.ht),  40);
    chk("A_pix_per_frame",     32'(done_cnt), 288);
    chk("A_first_x",           32'(done_fx), 0);
    chk("A_first_y",           32'(done_fy), 0);
    chk("A_last_x",            32'(done_lx), 23);
    chk("A_last_y",            32'(done_ly), 11);
    chk("A_no_sync_err",       32'(err_cnt - err_base), 0);
`ifdef VGA_RX_FRAME_SUM_EN
    chk("A_frame_sum",         32'(frame_sum), 864);
`else
    chk("A_frame_sum",         32'(frame_sum), 0);
`endif
    const_rgb = 1'b0;

    // One short line while locked, then relock.
    err_base = err_cnt;
    small_frame(7, -1);
    chk("B_sync_err_once",     32'(err_cnt - err_base), 1);
    chk("B_unlocked",          32'(locked), 0);
    small_frame(-1, -1);
    small_frame(-1, -1);
    chk("B_still_unlocked",    32'(locked), 0);
    small_frame(-1, -1);
    chk("B_relocked",          32'(locked), 1);
    chk("B_single_err",        32'(err_cnt - err_base), 1);

    // Mid-frame reset: two complete frames needed afterwards.
    small_frame(-1, 8);
    small_frame(-1, -1);
    small_frame(-1, -1);
    chk("C_unlocked_2frames",  32'(locked), 0);
    small_frame(-1, -1);
    chk("C_relocked",          32'(locked), 1);

    // Full-width 800-sample lines (640 active), short frame height.
    do_reset();
    send_frame(800, 96, 48, 640, 4, 1, 0, 2, 4, -1, -1);
    send_frame(800, 96, 48, 640, 4, 1, 0, 2, 4, -1, -1);
    send_frame(800, 96, 48, 640, 4, 1, 0, 2, 1, -1, -1);
    chk("D_h_total",           32'(h_total), 800);
    chk("D_v_total",           32'(v_total), 4);
    chk("D_locked",            32'(locked), 1);
    chk("D_pix_per_frame",     32'(done_cnt), 1280);
    chk("D_first_x",           32'(done_fx), 0);
    chk("D_last_x",            32'(done_lx), 639);
    chk("D_last_y",            32'(done_ly), 1);

    // 525-line frames, narrow lines; syncs always assert together.
    do_reset();
    fs_base  = fs_cnt;
    err_base = err_cnt;
    send_frame(8, 2, 1, 4, 525, 2, 33, 480, 525, -1, -1);
    send_frame(8, 2, 1, 4, 525, 2, 33, 480, 525, -1, -1);
    send_frame(8, 2, 1, 4, 525, 2, 33, 480, 1, -1, -1);
    chk("E_v_total",           32'(v_total), 525);
    chk("E_h_total",           32'(h_total), 8);
    chk("E_locked",            32'(locked), 1);
    chk("E_frame_starts",      32'(fs_cnt - fs_base), 3);
    chk("E_pix_per_frame",     32'(done_cnt), 1920);
    chk("E_first_y",           32'(done_fy), 0);
    chk("E_last_x",            32'(done_lx), 3);
    chk("E_last_y",            32'(done_ly), 479);
    chk("E_no_sync_err",       32'(err_cnt - err_base), 0);

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter N, default 15; counters and measurement outputs are N+1 bits wide.
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port pix_en  input  1  pixel strobe; all video inputs are sampled only in cycles where pix_en=1.
REQ-005 SHALL have ports R, G, B  input  8 each  pixel colour.
REQ-006 SHALL have ports horiz_sync, vert_sync  input  1 each  active-low syncs.
REQ-007 SHALL have port vga_blank  input  1  1 = active video, 0 = blanking.
REQ-008 SHALL have ports pix_x, pix_y  output  N+1 each  active-pixel coordinates.
REQ-009 SHALL have port pix_valid  output  1  one-cycle pulse qualifying pix_x, pix_y and pix_R/G/B.
REQ-010 SHALL have ports pix_R, pix_G, pix_B  output  8 each  registered pixel colour.
REQ-011 SHALL have ports h_total, v_total  output  N+1 each  measured samples per line and lines per frame.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on each vert_sync assertion.
REQ-013 SHALL have ports locked, sync_err  output  1 each  lock status and one-cycle error pulse.
REQ-014 SHALL have port frame_sum  output  16  per-frame pixel checksum.

Function
REQ-015 SHALL detect sync assertion as a 1->0 change between consecutive pix_en samples; edge-detect registers update only when pix_en=1.
REQ-016 SHALL clear h_cnt on a horiz_sync assertion and otherwise increment it per sample, saturating at 2^(N+1)-1; on each assertion it SHALL latch h_total = h_cnt+1.
REQ-017 SHALL increment v_cnt on each horiz_sync assertion; on a vert_sync assertion it SHALL latch v_total = v_cnt, or v_cnt+1 if horiz_sync asserts in the same sample, then clear v_cnt.
REQ-018 SHALL clear x on each horiz_sync assertion and increment it after each sample with vga_blank=1.
REQ-019 SHALL track active lines: y increments at the horiz_sync assertion following a line that contained at least one active sample, and clears on a vert_sync assertion.
REQ-020 For each sample with vga_blank=1, SHALL pulse pix_valid exactly one clk after the sampling cycle, with pix_x=x, pix_y=y and pix_R/G/B equal to the sampled colour.
REQ-021 SHALL pulse frame_start one clk after the sample containing the vert_sync assertion.
REQ-022 SHALL implement the lock FSM with states SEARCH, MEASURE and LOCKED:
- SEARCH, on a vert_sync assertion: go to MEASURE.
- MEASURE, on the next vert_sync assertion: store the reference h_total and v_total, then go to LOCKED if they equal the previous frame's values, else stay in MEASURE.
- LOCKED: locked=1.
- LOCKED, on a vert_sync assertion or horiz_sync assertion whose latched value differs from the reference: pulse sync_err and go to SEARCH.
REQ-023 SHALL hold locked=0 in SEARCH and MEASURE.
REQ-024 SHALL hold all outputs stable while pix_en=0; pulses never last more than one clk.

Reset
REQ-025 SHALL, while reset=0 at a rising clk edge:
- zero all counters, outputs and edge registers;
- set the previous-sync registers to 1, so no edge is detected on the first sample;
- enter SEARCH.
REQ-026 SHALL, when reset is applied mid-frame, discard partial measurements; lock requires two complete frames after reset release.

Configuration
REQ-027 With VGA_RX_FRAME_SUM_EN defined, SHALL accumulate R+G+B of every active sample modulo 2^16, latch the total into frame_sum on each vert_sync assertion, and clear the accumulator in the same cycle.
REQ-028 Without VGA_RX_FRAME_SUM_EN, SHALL tie frame_sum to 0 and omit the accumulator logic.

Verification
REQ-029 640x480 timing (800x525, pix_en every 2nd clk), three frames -> h_total=800, v_total=525, locked=1 after the third vert_sync assertion, sync_err never set.
REQ-030 Locked 640x480, one line shortened to 799 samples -> sync_err pulses once, locked=0, FSM in SEARCH; relock after two further clean frames.
REQ-031 Active region -> first pix_valid of the frame has pix_x=0, pix_y=0; last has pix_x=639, pix_y=479; exactly 307200 pix_valid pulses per frame.
REQ-032 Simultaneous horiz_sync and vert_sync assertion in one sample -> v_total=525, frame_start pulses once.
REQ-033 reset=0 for one clk mid-frame -> all outputs 0 next cycle, locked=0 until two full frames pass.
REQ-034 With VGA_RX_FRAME_SUM_EN, constant R=G=B=1 -> frame_sum = 921600 mod 65536 = 4096; without the macro -> frame_sum=0.
